// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if -- bundle between the core/hazard side and the fetch PC
// controller.
//   master : core side; drives stall, redirect and return-stack requests,
//            and observes the fetch address and NOP/hold strobes.
//   slave  : fetch_pc_ctrl.
// Ports:
//   stall, redirect_valid, redirect_target, ras_push, push_addr, ras_pop  (master -> slave)
//   address, PCctrl, PChold, ras_empty, ras_underflow                     (slave -> master)
// ADDR_W defaults to `MEM_SPACE; the macro falls back to 8 when the build
// does not define it.
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

interface fetch_pc_ctrl_if #(parameter int ADDR_W = `MEM_SPACE);
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              ras_push;
  logic [ADDR_W-1:0] push_addr;
  logic              ras_pop;
  logic [ADDR_W-1:0] address;
  logic              PCctrl;
  logic              PChold;
  logic              ras_empty;
  logic              ras_underflow;

  modport master (
    output stall, redirect_valid, redirect_target, ras_push, push_addr, ras_pop,
    input  address, PCctrl, PChold, ras_empty, ras_underflow
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, ras_push, push_addr, ras_pop,
    output address, PCctrl, PChold, ras_empty, ras_underflow
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl -- instruction fetch address sequencer.
// Generates the registered fetch address plus two decoded strobes:
//   PCctrl : memory returns a NOP this fetch (redirect flush window)
//   PChold : memory re-reads the held address (stalled fetch)
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fetch_pc_ctrl_if.slave (stall / redirect / return-stack requests,
//          address and status outputs)
// Build options:
//   RET_STACK_EN : when defined, a circular return-address stack of
//                  RAS_DEPTH entries supplies pop redirects. When undefined
//                  the stack inputs are ignored, ras_empty=1, ras_underflow=0.
// Parameters: ADDR_W (default `MEM_SPACE), FLUSH_CYCLES (1..7),
//             RAS_DEPTH (power of two).
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module fetch_pc_ctrl #(
  parameter int ADDR_W       = `MEM_SPACE,
  parameter int FLUSH_CYCLES = 2,
  parameter int RAS_DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [2:0]        FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] address, address_nxt;
  logic [2:0]        flush_cnt, flush_cnt_nxt;

  // Effective redirect after arbitrating redirect_valid over a stack pop.
  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;

`ifdef RET_STACK_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]     sp;        // index of the current top entry
  logic [PW:0]       depth;
  logic              empty, pop_ok, underflow;

  assign empty  = (depth == '0);
  // redirect_valid wins; a pop on an empty stack is dropped (and flagged)
  assign pop_ok = bus.ras_pop & ~bus.redirect_valid & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      depth     <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= bus.ras_pop & ~bus.redirect_valid & empty;
      if (pop_ok && !bus.ras_push) begin
        sp    <= sp - 1'b1;
        depth <= depth - 1'b1;
      end else if (!pop_ok && bus.ras_push) begin
        // Pointer wraps, so a push on a full stack lands on the oldest entry.
        sp <= sp + 1'b1;
        if (depth != FULL) depth <= depth + 1'b1;
      end
    end
  end

  // Storage needs no reset; depth alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && bus.ras_push) begin
      if (pop_ok) stack[sp] <= bus.push_addr;          // swap top in place
      else        stack[sp + 1'b1] <= bus.push_addr;
    end
  end

  assign redir             = bus.redirect_valid | pop_ok;
  assign redir_tgt         = bus.redirect_valid ? bus.redirect_target : stack[sp];
  assign bus.ras_empty     = empty;
  assign bus.ras_underflow = underflow;
`else
  assign redir             = bus.redirect_valid;
  assign redir_tgt         = bus.redirect_target;
  assign bus.ras_empty     = 1'b1;
  assign bus.ras_underflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      address   <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      address   <= address_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    address_nxt   = address;
    flush_cnt_nxt = flush_cnt;
    if (redir) begin
      // Redirect outranks stall and restarts any flush in progress.
      address_nxt   = redir_tgt;
      flush_cnt_nxt = FLUSH_INIT;
      state_nxt     = FLUSH;
    end else begin
      case (state)
        RUN: begin
          if (bus.stall) state_nxt   = STALL;
          else           address_nxt = address + ONE;
        end
        STALL: begin
          if (!bus.stall) begin
            address_nxt = address + ONE;
            state_nxt   = RUN;
          end
        end
        FLUSH: begin
          // Stall is ignored while NOPs are being fetched. Leaving the
          // window steps past the target, same as an ordinary RUN fetch.
          if (flush_cnt == '0) begin
            state_nxt   = RUN;
            address_nxt = address + ONE;
          end else begin
            flush_cnt_nxt = flush_cnt - 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign bus.address = address;
  assign bus.PChold  = (state == STALL);
  assign bus.PCctrl  = (state == FLUSH);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl (ADDR_W=8, FLUSH_CYCLES=2,
// RAS_DEPTH=4). Directed scenarios use fixed expected values; the random
// phase compares against a behavioural model: an integer address, a count of
// remaining NOP fetches, a held flag, and a queue standing in for the stack.
// Observed/expected vectors are {address, PCctrl, PChold, ras_empty, ras_underflow}.
module tb_fetch_pc_ctrl;
  localparam int AW = 8;
  localparam int FC = 2;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.ADDR_W(AW)) bus ();

  fetch_pc_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .RAS_DEPTH(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // ---------------- behavioural model ----------------
  int m_addr;
  int m_nop;          // NOP fetches still to be shown (PCctrl while > 0)
  bit m_hold;
  bit m_uf;
  int ras[$];

  task automatic model_step(input bit r, input bit st, input bit rv, input int rt,
                            input bit pu, input int pa, input bit po);
    bit redir;
    int tgt;
    bit popped;
    if (r) begin
      m_addr = 0; m_nop = 0; m_hold = 0; m_uf = 0;
      ras.delete();
      return;
    end
    redir  = rv;
    tgt    = rt;
    popped = 0;
    m_uf   = 0;
`ifdef RET_STACK_EN
    if (!rv && po) begin
      if (ras.size() > 0) begin
        popped = 1; redir = 1; tgt = ras[ras.size()-1];
      end else m_uf = 1;
    end
    if (popped && pu)  ras[ras.size()-1] = pa;
    else if (popped)   void'(ras.pop_back());
    else if (pu) begin
      ras.push_back(pa);
      if (ras.size() > RD) ras.delete(0);
    end
`endif
    if (redir) begin
      m_addr = tgt; m_nop = FC; m_hold = 0;
    end else if (m_nop > 0) begin
      m_nop--;
      if (m_nop == 0) m_addr = (m_addr + 1) % (1 << AW);
    end else if (st) begin
      m_hold = 1;
    end else begin
      m_addr = (m_addr + 1) % (1 << AW);
      m_hold = 0;
    end
  endtask

  function automatic logic [AW+3:0] model_obs();
    return {AW'(m_addr), (m_nop > 0), m_hold, (ras.size() == 0), m_uf};
  endfunction

  function automatic logic [AW+3:0] dut_obs();
    return {bus.address, bus.PCctrl, bus.PChold, bus.ras_empty, bus.ras_underflow};
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit r, input bit st, input bit rv, input logic [AW-1:0] rt,
                       input bit pu, input logic [AW-1:0] pa, input bit po);
    rst                 = r;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.ras_push        = pu;
    bus.push_addr       = pa;
    bus.ras_pop         = po;
    model_step(r, st, rv, int'(rt), pu, int'(pa), po);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [AW+3:0] exp;
    cycle(1, 1, 1, 8'h77, 1, 8'h12, 1);
    exp = {8'h00, 4'b0010};
    if (dut_obs() !== exp) begin
      mismatched++;
      $display("FAIL reset_state got=%h want=%h", dut_obs(), exp);
    end
    compared++;
  endtask

  task automatic test_count();
    logic [AW+3:0] exp;
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      exp = {AW'(k), 4'b0010};
      if (dut_obs() !== exp) begin
        mismatched++;
        $display("FAIL count step=%0d got=%h want=%h", k, dut_obs(), exp);
      end
      compared++;
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want [4];
    logic [AW+3:0] exp;
    want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 8'hFC, 0, 0, 0);      // lands at FC, leaves flush at FD
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      exp = {want[k], 4'b0010};
      if (dut_obs() !== exp) begin
        mismatched++;
        $display("FAIL wrap step=%0d got=%h want=%h", k, dut_obs(), exp);
      end
      compared++;
    end
  endtask

  task automatic test_stall();
    logic [AW+3:0] exp;
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cycle(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 0, 0, 0);
      exp = {8'h10, 4'b0110};
      if (dut_obs() !== exp) begin
        mismatched++;
        $display("FAIL stall_hold step=%0d got=%h want=%h", k, dut_obs(), exp);
      end
      compared++;
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    exp = {8'h11, 4'b0010};
    if (dut_obs() !== exp) begin
      mismatched++;
      $display("FAIL stall_release got=%h want=%h", dut_obs(), exp);
    end
    compared++;
  endtask

  task automatic test_redirect();
    logic [AW+3:0] exp [7];
    exp = '{{8'h40, 4'b1010}, {8'h40, 4'b1010}, {8'h41, 4'b0010},
            {8'h10, 4'b1010}, {8'h80, 4'b1010}, {8'h80, 4'b1010},
            {8'h81, 4'b0010}};
    cycle(0, 1, 1, 8'h40, 0, 0, 0);      // redirect beats stall
    if (dut_obs() !== exp[0]) begin mismatched++; $display("FAIL redir_0 got=%h want=%h", dut_obs(), exp[0]); end
    compared++;
    cycle(0, 1, 0, 0, 0, 0, 0);
    if (dut_obs() !== exp[1]) begin mismatched++; $display("FAIL redir_1 got=%h want=%h", dut_obs(), exp[1]); end
    compared++;
    cycle(0, 1, 0, 0, 0, 0, 0);          // stall ignored in flush; exits to RUN
    if (dut_obs() !== exp[2]) begin mismatched++; $display("FAIL redir_exit got=%h want=%h", dut_obs(), exp[2]); end
    compared++;
    cycle(0, 0, 1, 8'h10, 0, 0, 0);
    if (dut_obs() !== exp[3]) begin mismatched++; $display("FAIL redir_a got=%h want=%h", dut_obs(), exp[3]); end
    compared++;
    cycle(0, 1, 1, 8'h80, 0, 0, 0);      // redirect in first flush cycle restarts
    if (dut_obs() !== exp[4]) begin mismatched++; $display("FAIL redir_restart got=%h want=%h", dut_obs(), exp[4]); end
    compared++;
    cycle(0, 1, 0, 0, 0, 0, 0);
    if (dut_obs() !== exp[5]) begin mismatched++; $display("FAIL redir_restart2 got=%h want=%h", dut_obs(), exp[5]); end
    compared++;
    cycle(0, 1, 0, 0, 0, 0, 0);
    if (dut_obs() !== exp[6]) begin mismatched++; $display("FAIL redir_restart_exit got=%h want=%h", dut_obs(), exp[6]); end
    compared++;
  endtask

  task automatic test_stack();
`ifdef RET_STACK_EN
    logic [AW+3:0] exp [6];
    exp = '{{8'h01, 4'b0000}, {8'h02, 4'b0000}, {8'h32, 4'b1000},
            {8'h21, 4'b1010}, {8'h21, 4'b1011}, {8'h22, 4'b0010}};
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 8'h21, 0);
    if (dut_obs() !== exp[0]) begin mismatched++; $display("FAIL ras_push1 got=%h want=%h", dut_obs(), exp[0]); end
    compared++;
    cycle(0, 0, 0, 0, 1, 8'h32, 0);
    if (dut_obs() !== exp[1]) begin mismatched++; $display("FAIL ras_push2 got=%h want=%h", dut_obs(), exp[1]); end
    compared++;
    cycle(0, 0, 0, 0, 0, 0, 1);
    if (dut_obs() !== exp[2]) begin mismatched++; $display("FAIL ras_pop1 got=%h want=%h", dut_obs(), exp[2]); end
    compared++;
    cycle(0, 0, 0, 0, 0, 0, 1);
    if (dut_obs() !== exp[3]) begin mismatched++; $display("FAIL ras_pop2 got=%h want=%h", dut_obs(), exp[3]); end
    compared++;
    cycle(0, 0, 0, 0, 0, 0, 1);
    if (dut_obs() !== exp[4]) begin mismatched++; $display("FAIL ras_underflow got=%h want=%h", dut_obs(), exp[4]); end
    compared++;
    cycle(0, 0, 0, 0, 0, 0, 0);
    if (dut_obs() !== exp[5]) begin mismatched++; $display("FAIL ras_uf_pulse got=%h want=%h", dut_obs(), exp[5]); end
    compared++;
    // Overfill by one, then drain past empty: oldest entry must be gone.
    for (int k = 0; k < RD + 1; k++) cycle(0, 0, 0, 0, 1, AW'(8'hA0 + k), 0);
    for (int k = 0; k < RD + 1; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 1);
      if (dut_obs() !== model_obs()) begin
        mismatched++;
        $display("FAIL ras_overfill step=%0d got=%h want=%h", k, dut_obs(), model_obs());
      end
      compared++;
    end
`else
    logic [AW+3:0] exp [3];
    exp = '{{8'h01, 4'b0010}, {8'h02, 4'b0010}, {8'h03, 4'b0010}};
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 8'h21, 0);
    if (dut_obs() !== exp[0]) begin mismatched++; $display("FAIL ras_off_push got=%h want=%h", dut_obs(), exp[0]); end
    compared++;
    cycle(0, 0, 0, 0, 1, 8'h32, 1);
    if (dut_obs() !== exp[1]) begin mismatched++; $display("FAIL ras_off_pushpop got=%h want=%h", dut_obs(), exp[1]); end
    compared++;
    cycle(0, 0, 0, 0, 0, 0, 1);
    if (dut_obs() !== exp[2]) begin mismatched++; $display("FAIL ras_off_pop got=%h want=%h", dut_obs(), exp[2]); end
    compared++;
`endif
  endtask

  task automatic test_reset_midstate();
    logic [AW+3:0] exp;
    exp = {8'h00, 4'b0010};
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 8'h55, 0);
    cycle(0, 0, 1, 8'h30, 0, 0, 0);       // first flush cycle
    cycle(0, 0, 0, 0, 0, 0, 0);           // second flush cycle
    cycle(1, 1, 1, 8'h99, 1, 8'h66, 1);
    if (dut_obs() !== exp) begin
      mismatched++;
      $display("FAIL reset_mid_flush got=%h want=%h", dut_obs(), exp);
    end
    compared++;
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);           // now stalled
    cycle(1, 1, 0, 0, 0, 0, 1);
    if (dut_obs() !== exp) begin
      mismatched++;
      $display("FAIL reset_mid_stall got=%h want=%h", dut_obs(), exp);
    end
    compared++;
  endtask

  task automatic test_random();
    bit r, st, rv, pu, po;
    logic [AW-1:0] rt, pa;
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 500; k++) begin
      r  = ($urandom_range(99) < 2);
      st = ($urandom_range(99) < 35);
      rv = ($urandom_range(99) < 10);
      pu = ($urandom_range(99) < 25);
      po = ($urandom_range(99) < 20);
      rt = ($urandom_range(3) == 0) ? 8'hFE : AW'($urandom);
      pa = AW'($urandom);
      cycle(r, st, rv, rt, pu, pa, po);
      if (dut_obs() !== model_obs()) begin
        mismatched++;
        $display("FAIL random cyc=%0d got=%h want=%h", k, dut_obs(), model_obs());
      end
      compared++;
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_stall();
    test_redirect();
    test_stack();
    test_reset_midstate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
